key_loader: RTL

- Sequential key-delivery stage that sits directly upstream of the 32-bit RLL-locked combinational netlists; its key_out drives the keyIn_0_0..keyIn_0_31 bus.
- Receives the key serially from a secure-storage or scan source and checks it with one even-parity bit.
- Commits the key to a held register and presents it with a valid flag.
- The locked circuit sees only fully checked keys, never a partially shifted value.

---
 rtl/key_loader_pkg.sv | 18 +
 rtl/key_shift_reg.sv | 45 ++++
 rtl/key_loader.sv | 110 +++++++++++
 3 files changed

// File: rtl/key_loader_pkg.sv
// Shared types and helpers for the serial key loader and its bench.
package key_loader_pkg;

  localparam int KEY_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_t;

  // Even-parity bit that must follow a key on the serial line.
  function automatic logic key_parity(input logic [KEY_W_DEFAULT-1:0] key);
    return ^key;
  endfunction

endpackage

// File: rtl/key_shift_reg.sv
// Serial-to-parallel shadow register with saturating bit counter and running parity.
module key_shift_reg
  import key_loader_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEFAULT,
  parameter int CNT_W = $clog2(KEY_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             clr,
  input  logic             sdi,
  output logic [KEY_W-1:0] shadow,
  output logic             par,
  output logic [CNT_W-1:0] cnt
);

  logic [KEY_W-1:0] r_shadow;
  logic             r_par;
  logic [CNT_W-1:0] r_cnt;

  // The parity bit arrives with r_cnt == KEY_W; it is judged upstream and never stored here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow <= '0;
      r_par    <= 1'b0;
      r_cnt    <= '0;
    end else if (clr) begin
      r_shadow <= '0;
      r_par    <= 1'b0;
      r_cnt    <= '0;
    end else if (shift_en && (r_cnt != CNT_W'(KEY_W))) begin
      for (int i = 0; i < KEY_W; i++) begin
        if (r_cnt == CNT_W'(i)) r_shadow[i] <= sdi;
      end
      r_par <= r_par ^ sdi;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign shadow = r_shadow;
  assign par    = r_par;
  assign cnt    = r_cnt;

endmodule

// File: rtl/key_loader.sv
// Serial key loader: shifts KEY_W bits plus one even-parity bit and commits only checked keys.
// Optional one-time lock after first commit: define KEY_LOADER_OTP_LOCK_EN.
module key_loader
  import key_loader_pkg::*;
#(
  parameter int KEY_W = KEY_W_DEFAULT,
  parameter int CNT_W = $clog2(KEY_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sdi,
  input  logic             sdi_valid,
  output logic             sdi_ready,
  output logic             busy,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             key_err
`ifdef KEY_LOADER_OTP_LOCK_EN
  ,
  output logic             key_locked
`endif
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [KEY_W-1:0] r_key;
  logic [KEY_W-1:0] w_shadow;
  logic             w_par;
  logic [CNT_W-1:0] w_cnt;
  logic             w_start;
  logic             w_accept;
  logic             w_last;
  logic             w_par_ok;
  logic             w_commit;
  logic             w_clr;

  key_shift_reg #(
    .KEY_W(KEY_W),
    .CNT_W(CNT_W)
  ) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (w_accept),
    .clr      (w_clr),
    .sdi      (sdi),
    .shadow   (w_shadow),
    .par      (w_par),
    .cnt      (w_cnt)
  );

`ifdef KEY_LOADER_OTP_LOCK_EN
  logic r_lock;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_lock <= 1'b0;
    else if (w_commit) r_lock <= 1'b1;
  end

  assign w_start    = start & ~r_lock;
  assign key_locked = r_lock;
`else
  assign w_start = start;
`endif

  assign w_accept = sdi_valid & (r_state == SHIFT);
  assign w_last   = w_accept & (w_cnt == CNT_W'(KEY_W));
  assign w_par_ok = ~(w_par ^ sdi);
  assign w_commit = w_last & w_par_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // start is only honoured outside SHIFT, so a running load cannot be restarted.
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    sdi_ready   = 1'b0;
    busy        = 1'b0;
    key_valid   = 1'b0;
    key_err     = 1'b0;
    unique case (r_state)
      SHIFT: begin
        sdi_ready = 1'b1;
        busy      = 1'b1;
        if (w_last) w_state_nxt = w_par_ok ? DONE : ERROR;
      end
      default: begin
        key_valid = (r_state == DONE);
        key_err   = (r_state == ERROR);
        if (w_start) begin
          w_state_nxt = SHIFT;
          w_clr       = 1'b1;
          key_valid   = 1'b0;
          key_err     = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_key <= '0;
    else if (w_commit) r_key <= w_shadow;
  end

  assign key_out = r_key;

endmodule
